// File: rtl/countdown_timer_if.sv
// Control-unit <-> countdown_timer handshake: load request, run control and status/count readback.
interface countdown_timer_if #(
  parameter int SIZE = 16
);
  logic            load;
  logic [SIZE-1:0] load_value;
  logic            pause;
  logic            abort;
  logic            ready;
  logic            busy;
  logic            done;
  logic [SIZE-1:0] count_out;

  modport master (
    output load, load_value, pause, abort,
    input  ready, busy, done, count_out
  );

  modport slave (
    input  load, load_value, pause, abort,
    output ready, busy, done, count_out
  );
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter stepping by AMOUNT toward zero, one-cycle done pulse.
// Optional COUNTDOWN_AUTO_RELOAD_EN: restart from the last loaded value after every done.
module countdown_timer #(
  parameter int SIZE   = 16,
  parameter int AMOUNT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  countdown_timer_if.slave bus
);
  localparam logic [SIZE-1:0] STEP = SIZE'(AMOUNT);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;

  state_t          r_state;
  logic [SIZE-1:0] r_count;
  logic            r_ready;
  logic            r_busy;
  logic            r_done;
  logic [SIZE-1:0] w_next;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [SIZE-1:0] r_reload;
`endif

  // Saturating step: anything at or below STEP lands on zero instead of wrapping.
  function automatic logic [SIZE-1:0] f_sat_dec(input logic [SIZE-1:0] v);
    return (v > STEP) ? (v - STEP) : '0;
  endfunction

  assign w_next = f_sat_dec(r_count);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      r_reload <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.load) begin
            r_count <= bus.load_value;
            r_ready <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            r_reload <= bus.load_value;
`endif
            if (bus.load_value == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_COUNT;
              r_busy  <= 1'b1;
            end
          end
        end

        S_COUNT: begin
          if (bus.abort) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else if (!bus.pause) begin
            r_count <= w_next;
            if (r_count <= STEP) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end

        S_DONE: begin
          r_done <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          if (r_reload != '0) begin
            r_count <= r_reload;
            r_state <= S_COUNT;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end
`else
          r_state <= S_IDLE;
          r_ready <= 1'b1;
`endif
        end

        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready     = r_ready;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.count_out = r_count;
endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: two instances (AMOUNT=1 and AMOUNT=3) share stimulus and are
// compared every cycle against a behavioural model, plus directed scenario checks.
module tb_countdown_timer;
  localparam int SIZE = 16;
  localparam int AMT [2] = '{1, 3};

  logic            clk;
  logic            rst_n;
  logic            load;
  logic [SIZE-1:0] lv;
  logic            pause;
  logic            abort;

  int n_checks = 0;
  int n_errors = 0;

  int m_cnt  [2];
  bit m_run  [2];
  bit m_fire [2];
  int m_rel  [2];

  int seq2 [6] = '{5, 4, 3, 2, 1, 0};
  int seq3 [4] = '{7, 4, 1, 0};

  countdown_timer_if #(.SIZE(SIZE)) if1 ();
  countdown_timer_if #(.SIZE(SIZE)) if3 ();

  assign if1.load = load;  assign if1.load_value = lv;  assign if1.pause = pause;  assign if1.abort = abort;
  assign if3.load = load;  assign if3.load_value = lv;  assign if3.pause = pause;  assign if3.abort = abort;

  countdown_timer #(.SIZE(SIZE), .AMOUNT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  countdown_timer #(.SIZE(SIZE), .AMOUNT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: remaining count as a plain integer, plus "running" and "firing done" flags.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_cnt[k] = 0; m_run[k] = 0; m_fire[k] = 0;
      end else if (m_fire[k]) begin
        m_fire[k] = 0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        if (m_rel[k] != 0) begin
          m_cnt[k] = m_rel[k]; m_run[k] = 1;
        end
`endif
      end else if (m_run[k]) begin
        if (abort) m_run[k] = 0;
        else if (!pause) begin
          m_cnt[k] = (m_cnt[k] - AMT[k] < 0) ? 0 : m_cnt[k] - AMT[k];
          if (m_cnt[k] == 0) begin
            m_run[k] = 0; m_fire[k] = 1;
          end
        end
      end else if (load) begin
        m_cnt[k] = int'(lv);
        m_rel[k] = int'(lv);
        if (lv == 0) m_fire[k] = 1;
        else         m_run[k]  = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("a1_ready", 32'(if1.ready), 32'(!(m_run[0] || m_fire[0])));
    chk("a1_busy",  32'(if1.busy),  32'(m_run[0]));
    chk("a1_done",  32'(if1.done),  32'(m_fire[0]));
    chk("a1_count", 32'(if1.count_out), 32'(m_cnt[0]));
    chk("a3_ready", 32'(if3.ready), 32'(!(m_run[1] || m_fire[1])));
    chk("a3_busy",  32'(if3.busy),  32'(m_run[1]));
    chk("a3_done",  32'(if3.done),  32'(m_fire[1]));
    chk("a3_count", 32'(if3.count_out), 32'(m_cnt[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  // Two abort cycles guarantee both instances are idle whatever phase they were in.
  task automatic quiesce();
    load = 0; pause = 0; abort = 1;
    tick(); tick();
    abort = 0;
    tick();
  endtask

  initial begin
    int n;
    int last;
    int pulses;
    int r;

    rst_n = 0; load = 0; lv = '0; pause = 0; abort = 0;
    tick(); tick();
    rst_n = 1;
    tick();
    chk("rst_ready", 32'(if1.ready), 32'd1);
    chk("rst_busy",  32'(if1.busy),  32'd0);
    chk("rst_done",  32'(if1.done),  32'd0);
    chk("rst_count", 32'(if1.count_out), 32'd0);

    // V=5 on the AMOUNT=1 instance
    load = 1; lv = 16'd5;
    tick();
    load = 0;
    chk("t2_busy", 32'(if1.busy), 32'd1);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      chk("t2_count", 32'(if1.count_out), 32'(seq2[i]));
      chk("t2_done",  32'(if1.done), 32'(i == 5));
    end
    tick();
`ifndef COUNTDOWN_AUTO_RELOAD_EN
    chk("t2_ready", 32'(if1.ready), 32'd1);
`endif
    quiesce();

    // V=7 on the AMOUNT=3 instance saturates at zero
    load = 1; lv = 16'd7;
    tick();
    load = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      chk("t3_count", 32'(if3.count_out), 32'(seq3[i]));
      chk("t3_done",  32'(if3.done), 32'(i == 3));
    end
    quiesce();

    // V=10 with a 4-cycle pause at count 6
    load = 1; lv = 16'd10;
    tick();
    load = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("t4_at6", 32'(if1.count_out), 32'd6);
    pause = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_hold", 32'(if1.count_out), 32'd6);
    end
    pause = 0;
    n = 8;
    while (!if1.done && n < 40) begin
      tick();
      n++;
    end
    chk("t4_latency", 32'(n), 32'd14);
    quiesce();

    // V=100 aborted at count 40, then a V=0 load
    load = 1; lv = 16'd100;
    tick();
    load = 0;
    for (int i = 0; i < 60; i++) tick();
    chk("t5_at40", 32'(if1.count_out), 32'd40);
    abort = 1;
    tick();
    abort = 0;
    chk("t5_ready", 32'(if1.ready), 32'd1);
    chk("t5_busy",  32'(if1.busy),  32'd0);
    chk("t5_count", 32'(if1.count_out), 32'd40);
    chk("t5_nodone", 32'(if1.done), 32'd0);
    load = 1; lv = 16'd0;
    tick();
    load = 0;
    chk("t5_zdone", 32'(if1.done), 32'd1);
    chk("t5_zbusy", 32'(if1.busy), 32'd0);
    tick();
    chk("t5_zdone2", 32'(if1.done), 32'd0);
    chk("t5_zbusy2", 32'(if1.busy), 32'd0);
    chk("t5_zready", 32'(if1.ready), 32'd1);
    quiesce();

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    // Periodic done with V=3
    load = 1; lv = 16'd3;
    tick();
    load = 0;
    last = -1;
    pulses = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (if1.done) begin
        if (last >= 0) chk("t6_period", 32'(i - last), 32'd4);
        last = i;
        pulses++;
      end
    end
    chk("t6_pulses", 32'(pulses >= 3), 32'd1);
`endif

    // Reset in the middle of a run
    load = 1; lv = 16'd20;
    tick();
    load = 0;
    tick(); tick();
    rst_n = 0;
    tick();
    chk("mid_rst_ready", 32'(if1.ready), 32'd1);
    chk("mid_rst_busy",  32'(if1.busy),  32'd0);
    chk("mid_rst_done",  32'(if1.done),  32'd0);
    chk("mid_rst_count", 32'(if1.count_out), 32'd0);
    rst_n = 1;
    tick();

    // Random traffic
    for (int c = 0; c < 2000; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      load  = ($urandom_range(0, 3) == 0);
      r = int'($urandom_range(0, 99));
      if (r < 8)       lv = 16'd0;
      else if (r < 12) lv = 16'hFFFF;
      else if (r < 18) lv = 16'd3;
      else             lv = 16'($urandom_range(1, 40));
      pause = ($urandom_range(0, 4) == 0);
      abort = ($urandom_range(0, 29) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
